// File: rtl/sky_pkg.sv
// sky_pkg
//   Shared definitions for the falling-object game logic: display and
//   object geometry defaults, per-tick step sizes, the object state
//   machine encoding and the spawn-position LFSR (seed, taps, next-value).
//   No ports; imported by the falling_object_stepper top.
package sky_pkg;

  localparam int SCREEN_W = 96;  // display width, pixels
  localparam int SCREEN_H = 64;  // display height, pixels
  localparam int OBJ_W    = 4;   // object width, pixels
  localparam int OBJ_H    = 4;   // object height, pixels
  localparam int STEP_PX  = 1;   // base descent per step tick, pixels
  localparam int MAX_STEP = 4;   // descent ceiling when the speed-up build is used

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPAWN  = 2'd1,
    FALL   = 2'd2,
    LANDED = 2'd3
  } fall_state_t;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting left: feedback from bits 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Maximal-length sequence, so a non-zero seed never reaches zero.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tick_sync.sv
// tick_sync
//   Brings an asynchronous slow square wave into the basys_clock domain
//   through two flops and converts each rising edge into a single-cycle
//   pulse. The pulse is high during the third clock period after the
//   input rises and is consumed on the edge that ends it.
// Ports
//   basys_clock  in   system clock
//   reset        in   asynchronous, active-high
//   in           in   slow square wave (data, never a clock)
//   pulse        out  one-cycle rising-edge pulse
module tick_sync (
  input  logic basys_clock,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge basys_clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/falling_object_stepper.sv
// falling_object_stepper
//   Drives one falling object on the 96x64 OLED. Each rising edge of the
//   slow game clock becomes a step tick that lowers the object; a hit from
//   the player logic catches it, reaching the floor lands it. A free-running
//   LFSR picks the spawn column.
// Ports
//   basys_clock  in   100 MHz system clock, only clock
//   reset        in   asynchronous, active-high
//   slow_clock   in   divider square wave, sampled as data
//   enable       in   game running
//   hit          in   player overlaps object (level)
//   obj_x        out  object left edge, 0..SCREEN_W-OBJ_W
//   obj_y        out  object top edge, 0..SCREEN_H-OBJ_H
//   obj_valid    out  object on screen
//   caught       out  one-cycle catch pulse
//   landed       out  one-cycle floor-landing pulse
//   catch_count  out  catches since reset, wraps 255->0
// Configuration
//   FALL_SPEEDUP_EN: when defined, the step grows by one pixel every eight
//   catches up to MAX_STEP; otherwise the step is STEP_PX.
module falling_object_stepper #(
  parameter int SCREEN_W = sky_pkg::SCREEN_W,
  parameter int SCREEN_H = sky_pkg::SCREEN_H,
  parameter int OBJ_W    = sky_pkg::OBJ_W,
  parameter int OBJ_H    = sky_pkg::OBJ_H,
  parameter int STEP_PX  = sky_pkg::STEP_PX
) (
  input  logic       basys_clock,
  input  logic       reset,
  input  logic       slow_clock,
  input  logic       enable,
  input  logic       hit,
  output logic [6:0] obj_x,
  output logic [5:0] obj_y,
  output logic       obj_valid,
  output logic       caught,
  output logic       landed,
  output logic [7:0] catch_count
);

  import sky_pkg::*;

  localparam int X_SPAN  = SCREEN_W - OBJ_W + 1;  // number of legal columns
  localparam int Y_FLOOR = SCREEN_H - OBJ_H;      // lowest legal top edge

  fall_state_t state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [6:0]  obj_x_q, obj_x_d;
  logic [5:0]  obj_y_q, obj_y_d;
  logic        obj_valid_q, obj_valid_d;
  logic        caught_q, caught_d;
  logic        landed_q, landed_d;
  logic [7:0]  catch_count_q, catch_count_d;

  logic        step_tick;
  logic [6:0]  spawn_x;
  logic [6:0]  step;
  logic [6:0]  y_sum;
  logic        at_floor;

  tick_sync u_tick_sync (
    .basys_clock (basys_clock),
    .reset       (reset),
    .in          (slow_clock),
    .pulse       (step_tick)
  );

  always_comb lfsr_d = lfsr_next(lfsr_q);

  // Fold the 0..127 LFSR field onto the legal columns with one subtraction;
  // 127 - X_SPAN stays inside the range, so one fold is always enough.
  always_comb begin
    if (lfsr_q[6:0] < 7'(X_SPAN)) spawn_x = lfsr_q[6:0];
    else                          spawn_x = lfsr_q[6:0] - 7'(X_SPAN);
  end

`ifdef FALL_SPEEDUP_EN
  logic [6:0] step_raw;
  always_comb begin
    step_raw = 7'(STEP_PX) + {2'b00, catch_count_q[7:3]};
    step     = (step_raw > 7'(MAX_STEP)) ? 7'(MAX_STEP) : step_raw;
  end
`else
  assign step = 7'(STEP_PX);
`endif

  // One spare bit so a large step near the floor cannot wrap past it.
  assign y_sum    = {1'b0, obj_y_q} + step;
  assign at_floor = (y_sum >= 7'(Y_FLOOR));

  // State register
  always_ff @(posedge basys_clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; in FALL, enable beats hit, and hit beats a step tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = SPAWN;
      SPAWN:   state_d = FALL;
      FALL: begin
        if (!enable)                  state_d = IDLE;
        else if (hit)                 state_d = SPAWN;
        else if (step_tick && at_floor) state_d = LANDED;
      end
      LANDED:  state_d = enable ? SPAWN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic, same priority as the next-state logic.
  always_comb begin
    obj_x_d       = obj_x_q;
    obj_y_d       = obj_y_q;
    obj_valid_d   = obj_valid_q;
    caught_d      = 1'b0;
    landed_d      = 1'b0;
    catch_count_d = catch_count_q;
    case (state_q)
      IDLE:   obj_valid_d = 1'b0;
      SPAWN: begin
        obj_x_d     = spawn_x;
        obj_y_d     = 6'd0;
        obj_valid_d = 1'b1;
      end
      FALL: begin
        if (!enable) begin
          obj_valid_d = 1'b0;
        end else if (hit) begin
          caught_d      = 1'b1;
          catch_count_d = catch_count_q + 8'd1;
          obj_valid_d   = 1'b0;
        end else if (step_tick) begin
          if (at_floor) begin
            obj_y_d     = 6'(Y_FLOOR);
            landed_d    = 1'b1;
            obj_valid_d = 1'b0;
          end else begin
            obj_y_d = y_sum[5:0];
          end
        end
      end
      LANDED:  obj_valid_d = 1'b0;
      default: obj_valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge basys_clock or posedge reset) begin
    if (reset) begin
      lfsr_q        <= LFSR_SEED;
      obj_x_q       <= 7'd0;
      obj_y_q       <= 6'd0;
      obj_valid_q   <= 1'b0;
      caught_q      <= 1'b0;
      landed_q      <= 1'b0;
      catch_count_q <= 8'd0;
    end else begin
      lfsr_q        <= lfsr_d;
      obj_x_q       <= obj_x_d;
      obj_y_q       <= obj_y_d;
      obj_valid_q   <= obj_valid_d;
      caught_q      <= caught_d;
      landed_q      <= landed_d;
      catch_count_q <= catch_count_d;
    end
  end

  assign obj_x       = obj_x_q;
  assign obj_y       = obj_y_q;
  assign obj_valid   = obj_valid_q;
  assign caught      = caught_q;
  assign landed      = landed_q;
  assign catch_count = catch_count_q;

endmodule

// File: tb/tb_falling_object_stepper.sv
// tb_falling_object_stepper
//   Directed stimulus for falling_object_stepper. Stimulus tasks push the
//   expected spawn / catch / landing events into a queue; a monitor on the
//   falling clock edge pops and compares each event the DUT presents.
module tb_falling_object_stepper;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       slow_clock = 1'b0;
  logic       enable = 1'b0;
  logic       hit = 1'b0;
  logic [6:0] obj_x;
  logic [5:0] obj_y;
  logic       obj_valid;
  logic       caught;
  logic       landed;
  logic [7:0] catch_count;

  always #5 clk = ~clk;

  falling_object_stepper dut (
    .basys_clock (clk),
    .reset       (reset),
    .slow_clock  (slow_clock),
    .enable      (enable),
    .hit         (hit),
    .obj_x       (obj_x),
    .obj_y       (obj_y),
    .obj_valid   (obj_valid),
    .caught      (caught),
    .landed      (landed),
    .catch_count (catch_count)
  );

  // kind: 0 = spawn, 1 = caught, 2 = landed
  typedef struct {
    int kind;
    int y;
    int cnt;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         model_y = 0;
  int         exp_count = 0;
  logic [7:0] m_lfsr = 8'hA5;
  logic [7:0] prev_lfsr = 8'hA5;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic int spawn_col(input logic [7:0] l);
    int v;
    v = int'(l[6:0]);
    return (v < 93) ? v : v - 93;
  endfunction

  function automatic int model_step(input int c);
    int s;
`ifdef FALL_SPEEDUP_EN
    s = 1 + ((c % 256) >> 3);
    if (s > 4) s = 4;
`else
    s = 1;
`endif
    return s;
  endfunction

  task automatic push(input int kind, input int y, input int cnt);
    exp_t e;
    e.kind = kind;
    e.y    = y;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  // Reference LFSR: runs every clock, held at the seed while reset is high.
  initial begin
    forever begin
      @(posedge clk);
      prev_lfsr = m_lfsr;
      if (reset) m_lfsr = 8'hA5;
      else       m_lfsr = lfsr_step(m_lfsr);
    end
  end

  // Monitor / scoreboard
  initial begin : monitor
    logic v_prev;
    int   seen;
    exp_t e;
    v_prev = 1'b0;
    forever begin
      @(negedge clk);
      seen = -1;
      if (!reset) begin
        if (caught)                      seen = 1;
        else if (landed)                 seen = 2;
        else if (obj_valid && !v_prev)   seen = 0;
        if (caught || landed) check("pulse_exclusive", int'(caught && landed), 0);
        if (seen >= 0) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d, required none", seen);
          end else begin
            e = exp_q.pop_front();
            check("event_kind", seen, e.kind);
            if (seen == e.kind) begin
              case (seen)
                0: begin
                  check("spawn_x", int'(obj_x), spawn_col(prev_lfsr));
                  check("spawn_x_in_range", int'(obj_x <= 7'd92), 1);
                  check("spawn_y", int'(obj_y), 0);
                end
                1: begin
                  check("caught_y", int'(obj_y), e.y);
                  check("caught_count", int'(catch_count), e.cnt);
                  check("caught_valid", int'(obj_valid), 0);
                end
                default: begin
                  check("landed_y", int'(obj_y), e.y);
                  check("landed_valid", int'(obj_valid), 0);
                  check("landed_count", int'(catch_count), e.cnt);
                end
              endcase
            end
          end
        end
      end
      v_prev = reset ? 1'b0 : obj_valid;
    end
  end

  // One slow_clock rise; the step lands on the third edge after the rise,
  // and the low phase lets the edge detector re-arm before the next call.
  task automatic tick_rise();
    @(posedge clk); #1 slow_clock = 1'b1;
    repeat (4) @(posedge clk);
    #1 slow_clock = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic tick_check(input string tag);
    int st;
    st = model_step(exp_count);
    tick_rise();
    model_y += st;
    check(tag, int'(obj_y), model_y);
  endtask

  task automatic do_catch();
    exp_count++;
    push(1, model_y, exp_count % 256);
    push(0, 0, 0);
    @(posedge clk); #1 hit = 1'b1;
    @(posedge clk); #1 hit = 1'b0;
    check("catch_pulse", int'(caught), 1);
    check("catch_count", int'(catch_count), exp_count % 256);
    @(posedge clk); #1;
    check("catch_pulse_len", int'(caught), 0);
    check("respawn_valid", int'(obj_valid), 1);
    check("respawn_y", int'(obj_y), 0);
    model_y = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"}, int'(obj_x), 0);
    check({tag, "_y"}, int'(obj_y), 0);
    check({tag, "_valid"}, int'(obj_valid), 0);
    check({tag, "_caught"}, int'(caught), 0);
    check({tag, "_landed"}, int'(landed), 0);
    check({tag, "_count"}, int'(catch_count), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    // 1. reset with slow_clock toggling, then IDLE with enable low
    repeat (6) begin
      @(posedge clk); #1 slow_clock = ~slow_clock;
    end
    check_all_zero("reset");
    slow_clock = 1'b0;
    @(negedge clk) reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_valid", int'(obj_valid), 0);
    check("idle_y", int'(obj_y), 0);

    // 2. enable, fall all the way to the floor, respawn
    push(0, 0, 0);
    @(posedge clk); #1 enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("spawn_valid", int'(obj_valid), 1);
    check("spawn_y0", int'(obj_y), 0);
    model_y = 0;
    for (int i = 1; i <= 59; i++) tick_check("fall_y");
    push(2, 60, exp_count);
    push(0, 0, 0);
    tick_rise();
    model_y = 0;
    check("after_land_valid", int'(obj_valid), 1);
    check("after_land_y", int'(obj_y), 0);
    check("after_land_x_range", int'(obj_x <= 7'd92), 1);

    // 3. catch at obj_y = 20
    for (int i = 0; i < 20; i++) tick_check("fall_to_20");
    do_catch();

    // 4. hit in the same cycle as the step tick
    for (int i = 0; i < 5; i++) tick_check("fall_to_5");
    exp_count++;
    push(1, model_y, exp_count);
    push(0, 0, 0);
    @(posedge clk); #1 slow_clock = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 hit = 1'b1;
    @(posedge clk);
    #1 hit = 1'b0;
    check("tie_caught", int'(caught), 1);
    check("tie_landed", int'(landed), 0);
    check("tie_y_unchanged", int'(obj_y), model_y);
    @(posedge clk); #1 slow_clock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_y = 0;
    check("tie_respawn_y", int'(obj_y), 0);

    // 5. drop enable at obj_y = 30, hit while idle, re-enable
    for (int i = 0; i < 30; i++) tick_check("fall_to_30");
    @(posedge clk); #1 enable = 1'b0;
    @(posedge clk); #1;
    check("disable_valid", int'(obj_valid), 0);
    check("disable_caught", int'(caught), 0);
    check("disable_landed", int'(landed), 0);
    hit = 1'b1;
    repeat (3) @(posedge clk);
    #1 hit = 1'b0;
    check("idle_hit_count", int'(catch_count), exp_count);
    check("idle_hit_valid", int'(obj_valid), 0);
    push(0, 0, 0);
    @(posedge clk); #1 enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_y = 0;
    check("reenable_valid", int'(obj_valid), 1);
    check("reenable_y", int'(obj_y), 0);

    // asynchronous reset in the middle of a fall
    for (int i = 0; i < 3; i++) tick_check("fall_to_3");
    @(posedge clk); #3 reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    repeat (3) @(posedge clk);
    exp_count = 0;
    push(0, 0, 0);
    @(negedge clk) reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_y = 0;
    check("post_reset_valid", int'(obj_valid), 1);
    check("post_reset_y", int'(obj_y), 0);

`ifdef FALL_SPEEDUP_EN
    // 6. step grows every 8 catches, capped
    while (exp_count < 32) begin
      do_catch();
      if (exp_count == 8 || exp_count == 24 || exp_count == 32)
        tick_check("speedup_y");
    end
`endif

    repeat (6) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
